// File: rtl/spi_scene_scheduler.sv
// spi_scene_scheduler: decodes SPI packet headers, buffers payload words in a
// FIFO, drains them into scene RAM while the renderer is idle, schedules the
// frame commit (o_swap) and drives the MCU flow-control interrupt (o_irq).
// Optional build macro SPI_SCHED_STATS_EN adds the o_wr_count write counter.
module spi_scene_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 8,
  parameter int IRQ_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              i_dv,
  input  logic [63:0]       i_word,
  input  logic              i_render_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [63:0]       o_wr_data,
  output logic              o_swap,
  output logic              o_irq,
  output logic              o_err
`ifdef SPI_SCHED_STATS_EN
  ,
  output logic [15:0]       o_wr_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(IRQ_THRESH);

  typedef enum logic {R_HDR, R_PAY} rx_state_t;

  rx_state_t          state, state_n;
  logic [7:0]         rem;
  logic [ADDR_W-1:0]  idx, base;
  logic [ADDR_W+63:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_n;
  logic               commit_pending, pending_n;

  logic [3:0] opcode;
  logic [7:0] hdr_n;
  logic hdr_write, hdr_zero, hdr_commit, hdr_flush, hdr_bad, push_req;
  logic full, push_ok, pop, swap_fire, irq_n;

  assign opcode = i_word[63:60];
  assign hdr_n  = i_word[59:52];

  // Receive FSM state register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= R_HDR;
    else       state <= state_n;
  end

  // Receive FSM next state: a packet ends on the push that consumes rem==1
  always_comb begin
    state_n = state;
    case (state)
      R_HDR: if (hdr_write) state_n = R_PAY;
      R_PAY: if (i_dv && rem == 8'd1) state_n = R_HDR;
      default: state_n = R_HDR;
    endcase
  end

  // Receive FSM outputs: header decode strobes and payload push request
  always_comb begin
    hdr_write  = 1'b0;
    hdr_zero   = 1'b0;
    hdr_commit = 1'b0;
    hdr_flush  = 1'b0;
    hdr_bad    = 1'b0;
    push_req   = 1'b0;
    if (i_dv) begin
      if (state == R_HDR) begin
        case (opcode)
          4'hA: if (hdr_n != 8'd0) hdr_write = 1'b1; else hdr_zero = 1'b1;
          4'hC: hdr_commit = 1'b1;
          4'hF: hdr_flush  = 1'b1;
          default: hdr_bad = 1'b1;
        endcase
      end else begin
        push_req = 1'b1;
      end
    end
  end

  // Fullness is judged on the pre-pop count, so full+pop still drops the push;
  // a swap waits for queued words, the registered write and any same-cycle push
  always_comb begin
    full      = (count == DEPTH_C);
    push_ok   = push_req && !full;
    pop       = (count != '0) && !i_render_busy && !hdr_flush;
    swap_fire = commit_pending && (count == '0) && !o_wr_en && !i_render_busy && !push_req;
    count_n   = count;
    if (hdr_flush) count_n = '0;
    else if (push_ok && !pop) count_n = count + CNT_W'(1);
    else if (!push_ok && pop) count_n = count - CNT_W'(1);
    pending_n = commit_pending;
    if (hdr_flush || swap_fire) pending_n = 1'b0;
    else if (hdr_commit)        pending_n = 1'b1;
    irq_n = (state_n == R_HDR) && ((DEPTH_C - count_n) >= THRESH_C) && !pending_n;
  end

  // Packet bookkeeping: base address, word index and remaining count
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      base <= '0;
      idx  <= '0;
      rem  <= '0;
    end else if (hdr_write) begin
      base <= i_word[ADDR_W-1:0];
      idx  <= '0;
      rem  <= hdr_n;
    end else if (push_req) begin
      idx  <= idx + ADDR_W'(1);
      rem  <= rem - 8'd1;
    end
  end

  // FIFO storage: address travels with the data
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {base + idx, i_word};
  end

  // FIFO pointers, count, commit and error state
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      commit_pending <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      count          <= count_n;
      commit_pending <= pending_n;
      if (hdr_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        o_err  <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
        if (hdr_zero || hdr_bad || (push_req && full)) o_err <= 1'b1;
      end
    end
  end

  // Registered scene RAM write port, swap pulse and flow-control interrupt
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_swap    <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      o_wr_en <= pop;
      if (pop) {o_wr_addr, o_wr_data} <= mem[rd_ptr];
      o_swap  <= swap_fire;
      o_irq   <= irq_n;
    end
  end

`ifdef SPI_SCHED_STATS_EN
  // Saturating count of scene RAM writes
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                              o_wr_count <= '0;
    else if (hdr_flush)                     o_wr_count <= '0;
    else if (pop && o_wr_count != 16'hFFFF) o_wr_count <= o_wr_count + 16'd1;
  end
`endif

endmodule
